// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding source unit.
package fwd_pkg;
    localparam int DEF_REG_ADDRESS_LENGTH = 5;
    localparam int DEF_DATA_WIDTH         = 64;

    localparam logic [DEF_REG_ADDRESS_LENGTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                              valid;
        logic                              pending;
        logic [DEF_REG_ADDRESS_LENGTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0]         data;
    } stageEntry_t;

    localparam stageEntry_t STAGE_BUBBLE = '0;
endpackage

// File: rtl/fwd_source_unit_if.sv
// Bus between EX/decode/memory and the forwarding source unit.
interface fwd_source_unit_if import fwd_pkg::*; #(
    parameter int REG_ADDRESS_LENGTH = DEF_REG_ADDRESS_LENGTH,
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH
) ();
    logic                          ex_valid;
    logic [REG_ADDRESS_LENGTH-1:0] ex_rd;
    logic [DATA_WIDTH-1:0]         ex_data;
    logic                          ex_is_load;
    logic                          mem_load_valid;
    logic [DATA_WIDTH-1:0]         mem_load_data;
    logic                          flush;
    logic [REG_ADDRESS_LENGTH-1:0] query_rA;
    logic [REG_ADDRESS_LENGTH-1:0] query_rB;
    logic                          fwd_sel_rA;
    logic                          fwd_sel_rB;
    logic [DATA_WIDTH-1:0]         fwd_data_rA;
    logic [DATA_WIDTH-1:0]         fwd_data_rB;
    logic                          stall;
    logic                          wb_valid;
    logic [REG_ADDRESS_LENGTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]         wb_data;

    modport master (
        output ex_valid, ex_rd, ex_data, ex_is_load, mem_load_valid, mem_load_data,
               flush, query_rA, query_rB,
        input  fwd_sel_rA, fwd_sel_rB, fwd_data_rA, fwd_data_rB, stall,
               wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data, ex_is_load, mem_load_valid, mem_load_data,
               flush, query_rA, query_rB,
        output fwd_sel_rA, fwd_sel_rB, fwd_data_rA, fwd_data_rB, stall,
               wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/fwd_lookup.sv
// Priority compare of one decode source register against the S1/S2 entries.
module fwd_lookup import fwd_pkg::*; #(
    parameter int REG_ADDRESS_LENGTH = DEF_REG_ADDRESS_LENGTH,
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH
) (
    input  stageEntry_t                   s1,
    input  stageEntry_t                   s2,
    input  logic                          memLoadValid,
    input  logic [DATA_WIDTH-1:0]         memLoadData,
    input  logic [REG_ADDRESS_LENGTH-1:0] query,
    output logic                          sel,
    output logic [DATA_WIDTH-1:0]         data
);
    logic                  hit1;
    logic                  hit2;
    logic [DATA_WIDTH-1:0] s1Value;

    always_comb begin
        // An unfilled load in S1 must not match; stall keeps the stale S2 value unused.
        hit1    = s1.valid & (s1.rd != REG_ZERO) & (s1.rd == query) & (~s1.pending | memLoadValid);
        hit2    = s2.valid & (s2.rd != REG_ZERO) & (s2.rd == query);
        s1Value = (s1.pending & memLoadValid) ? memLoadData : s1.data;
        sel     = hit1 | hit2;
        data    = '0;
        if (hit1)
            data = s1Value;
        else if (hit2)
            data = s2.data;
    end
endmodule

// File: rtl/fwd_source_unit.sv
// MEM (S1) / WB (S2) result tracking with load stall, flush and operand forwarding.
module fwd_source_unit import fwd_pkg::*; #(
    parameter int REG_ADDRESS_LENGTH = DEF_REG_ADDRESS_LENGTH,
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH
) (
    input logic               clk,
    input logic               reset,
    fwd_source_unit_if.slave  bus
);
    stageEntry_t s1Q, s2Q;
    stageEntry_t s1Filled, s1Next, s2Next, exEntry;
    logic        fill;
    logic        stallInt;

    logic [DATA_WIDTH-1:0]         memData;
    logic [REG_ADDRESS_LENGTH-1:0] exRd;

    assign memData = bus.mem_load_data;
    assign exRd    = bus.ex_rd;

    always_comb begin
        fill     = s1Q.valid & s1Q.pending & bus.mem_load_valid;
        stallInt = s1Q.valid & s1Q.pending & ~bus.mem_load_valid;

        s1Filled = s1Q;
        if (fill) begin
            s1Filled.pending = 1'b0;
            s1Filled.data    = memData;
        end

        exEntry = '{valid:   bus.ex_valid,
                    pending: bus.ex_valid & bus.ex_is_load,
                    rd:      exRd,
                    data:    bus.ex_data};

        s1Next = s1Q;
        s2Next = STAGE_BUBBLE;
        if (bus.flush) begin
            // Only a completed S1 result survives a flush into writeback.
            s1Next = STAGE_BUBBLE;
            if (s1Q.valid & ~stallInt)
                s2Next = s1Filled;
        end else if (!stallInt) begin
            s1Next = exEntry;
            s2Next = s1Filled;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Q <= STAGE_BUBBLE;
            s2Q <= STAGE_BUBBLE;
        end else begin
            s1Q <= s1Next;
            s2Q <= s2Next;
        end
    end

    assign bus.stall    = stallInt;
    assign bus.wb_valid = s2Q.valid & (s2Q.rd != REG_ZERO);
    assign bus.wb_rd    = s2Q.rd;
    assign bus.wb_data  = s2Q.data;

    fwd_lookup #(.REG_ADDRESS_LENGTH(REG_ADDRESS_LENGTH), .DATA_WIDTH(DATA_WIDTH)) lookupA (
        .s1(s1Q), .s2(s2Q), .memLoadValid(bus.mem_load_valid), .memLoadData(memData),
        .query(bus.query_rA), .sel(bus.fwd_sel_rA), .data(bus.fwd_data_rA)
    );

    fwd_lookup #(.REG_ADDRESS_LENGTH(REG_ADDRESS_LENGTH), .DATA_WIDTH(DATA_WIDTH)) lookupB (
        .s1(s1Q), .s2(s2Q), .memLoadValid(bus.mem_load_valid), .memLoadData(memData),
        .query(bus.query_rB), .sel(bus.fwd_sel_rB), .data(bus.fwd_data_rB)
    );
endmodule
